// File: rtl/idx_alloc.sv
// idx_alloc: lowest-free-first index allocator with single release per cycle, occupancy and sticky error
module idx_alloc #(
  parameter int W = 32,
  localparam int IDX_W = $clog2(W),
  localparam int CNT_W = $clog2(W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_vld_i,
  output logic             alloc_rdy_o,
  output logic [IDX_W-1:0] alloc_idx_o,
  input  logic             free_vld_i,
  input  logic [IDX_W-1:0] free_idx_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             err_o
);
  localparam int PW = 1 << IDX_W;
  logic [W-1:0]  busy;
  logic [PW-1:0] busy_pad;
  logic [CNT_W-1:0] cnt;
  logic err, alloc_fire, free_legal;
  logic [W-1:0] set_mask, clr_mask;
  always_comb begin
    alloc_idx_o = '0;
    for (int i = W - 1; i >= 0; i--) alloc_idx_o = !busy[i] ? IDX_W'(i) : alloc_idx_o;
  end
  // padding bits read as idle, so out-of-range indices fall out as illegal frees
  assign busy_pad    = PW'(busy);
  assign full_o      = cnt == CNT_W'(W);
  assign empty_o     = cnt == '0;
  assign alloc_rdy_o = !full_o;
  assign cnt_o       = cnt;
  assign err_o       = err;
  assign alloc_fire  = alloc_vld_i && alloc_rdy_o;
  assign free_legal  = free_vld_i && busy_pad[free_idx_i];
  assign set_mask    = alloc_fire ? W'(1) << alloc_idx_o : '0;
  assign clr_mask    = free_legal ? W'(1) << free_idx_i : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
      cnt  <= '0;
      err  <= 1'b0;
    end else begin
      busy <= (busy | set_mask) & ~clr_mask;
      cnt  <= cnt + CNT_W'(alloc_fire) - CNT_W'(free_legal);
      err  <= err | (free_vld_i && !free_legal);
    end
  end
endmodule

// File: tb/tb_idx_alloc.sv
// tb_idx_alloc: table-driven check of idx_alloc (W=32) plus a W=5 instance for out-of-range frees
module tb_idx_alloc;
  logic clk = 0, rst = 1;
  logic a, fv, a5, fv5;
  logic [4:0] fi;
  logic [2:0] fi5;
  logic rdy, full, empty, err, rdy5, full5, empty5, err5;
  logic [4:0] idx;
  logic [5:0] cnt;
  logic [2:0] idx5, cnt5;
  int checks = 0, errors = 0;

  typedef struct {
    logic r, a, fv;
    logic [4:0] fi;
    int idx, cnt;
    logic rdy, err;
  } vec_t;
  vec_t v[$];

  always #5 clk = ~clk;

  idx_alloc #(.W(32)) dut (
    .clk(clk), .rst(rst), .alloc_vld_i(a), .alloc_rdy_o(rdy), .alloc_idx_o(idx),
    .free_vld_i(fv), .free_idx_i(fi), .cnt_o(cnt), .full_o(full), .empty_o(empty), .err_o(err)
  );
  idx_alloc #(.W(5)) dut5 (
    .clk(clk), .rst(rst), .alloc_vld_i(a5), .alloc_rdy_o(rdy5), .alloc_idx_o(idx5),
    .free_vld_i(fv5), .free_idx_i(fi5), .cnt_o(cnt5), .full_o(full5), .empty_o(empty5), .err_o(err5)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic al, input logic f, input int i,
                     input int ei, input int ec, input logic er, input logic ee);
    v.push_back('{r: r, a: al, fv: f, fi: 5'(i), idx: ei, cnt: ec, rdy: er, err: ee});
  endtask

  task automatic step5(input logic al, input logic f, input int i);
    a5 = al; fv5 = f; fi5 = 3'(i);
    @(posedge clk); #1;
  endtask

  initial begin
    a = 0; fv = 0; fi = 0; a5 = 0; fv5 = 0; fi5 = 0;
    // reset with requests pending
    add(1, 1, 1, 3, 0, 0, 1, 0);
    for (int i = 0; i < 32; i++) add(0, 1, 0, 0, i < 31 ? i + 1 : 0, i + 1, i < 31, 0);
    // full: free 17 then 5, refill in ascending order
    add(0, 0, 1, 17, 17, 31, 1, 0);
    add(0, 0, 1, 5, 5, 30, 1, 0);
    add(0, 1, 0, 0, 17, 31, 1, 0);
    add(0, 1, 0, 0, 0, 32, 0, 0);
    // full: alloc dropped, free accepted
    add(0, 1, 1, 9, 9, 31, 1, 0);
    add(0, 1, 0, 0, 0, 32, 0, 0);
    // reset mid-operation with both requests high
    add(1, 1, 1, 9, 0, 0, 1, 0);
    add(0, 1, 0, 0, 1, 1, 1, 0);
    add(0, 1, 0, 0, 2, 2, 1, 0);
    add(0, 1, 0, 0, 3, 3, 1, 0);
    add(0, 1, 1, 1, 1, 3, 1, 0);
    // double free of idle entries sets sticky err
    add(0, 0, 1, 4, 1, 3, 1, 1);
    add(0, 0, 1, 31, 1, 3, 1, 1);
    add(0, 1, 0, 0, 4, 4, 1, 1);
    add(0, 1, 0, 0, 5, 5, 1, 1);
    // reset in the middle of an alloc burst
    add(1, 1, 1, 0, 0, 0, 1, 0);
    add(0, 1, 0, 0, 1, 1, 1, 0);
    add(0, 0, 1, 0, 0, 0, 1, 0);
    add(0, 0, 1, 0, 0, 0, 1, 1);
    add(0, 1, 0, 0, 1, 1, 1, 1);
    for (int i = 0; i < v.size(); i++) begin
      rst = v[i].r; a = v[i].a; fv = v[i].fv; fi = v[i].fi;
      @(posedge clk); #1;
      check($sformatf("v%0d_cnt", i), int'(cnt), v[i].cnt);
      check($sformatf("v%0d_rdy", i), int'(rdy), int'(v[i].rdy));
      check($sformatf("v%0d_err", i), int'(err), int'(v[i].err));
      check($sformatf("v%0d_full", i), int'(full), int'(v[i].cnt == 32));
      check($sformatf("v%0d_empty", i), int'(empty), int'(v[i].cnt == 0));
      if (v[i].rdy) check($sformatf("v%0d_idx", i), int'(idx), v[i].idx);
    end
    rst = 0; a = 0; fv = 0;
    // W=5 instance: fill, then an out-of-range free
    rst = 1; step5(1, 1, 6); rst = 0;
    check("w5_rst_empty", int'(empty5), 1);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("w5_idx%0d", i), int'(idx5), i);
      step5(1, 0, 0);
    end
    check("w5_full", int'(full5), 1);
    check("w5_rdy", int'(rdy5), 0);
    check("w5_cnt_full", int'(cnt5), 5);
    step5(1, 0, 0);
    check("w5_drop_cnt", int'(cnt5), 5);
    step5(0, 1, 6);
    check("w5_oor_err", int'(err5), 1);
    check("w5_oor_cnt", int'(cnt5), 5);
    step5(0, 1, 2);
    check("w5_free2_cnt", int'(cnt5), 4);
    check("w5_free2_idx", int'(idx5), 2);
    check("w5_err_sticky", int'(err5), 1);
    step5(0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
